// File: rtl/zeroriscy_wb_stage.sv
// Write-back stage: merges EX results and LSU load returns onto the
// single register-file write port, tracks outstanding loads in a small
// FIFO, extracts and extends load data, and flags read-after-load hazards.
module zeroriscy_wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ex_we_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    output logic                  ex_ready_o,

    input  logic                  lsu_req_i,
    input  logic [ADDR_WIDTH-1:0] lsu_req_waddr_i,
    input  logic [1:0]            lsu_req_type_i,
    input  logic                  lsu_req_sign_ext_i,
    input  logic [1:0]            lsu_req_offset_i,
    output logic                  lsu_req_ready_o,

    input  logic                  lsu_rvalid_i,
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,

    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic                  hazard_o,
    output logic                  lq_empty_o,
    output logic                  lsu_err_o,

    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_we_o
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] waddr;
        logic [1:0]            ltype;
        logic                  sign_ext;
        logic [1:0]            offset;
    } lq_entry_t;

    lq_entry_t             lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  lq_full, lq_empty;
    logic                  push, pop, load_win;
    lq_entry_t             head;
    logic [DATA_WIDTH-1:0] load_data;
    logic [15:0]           half_lane;
    logic [7:0]            byte_lane;

    logic [LQ_DEPTH-1:0][PTR_W-1:0] rel_pos;
    logic [LQ_DEPTH-1:0]            entry_vld;
    logic [LQ_DEPTH-1:0]            entry_hit_a, entry_hit_b;
    logic                           hit_a, hit_b;

    assign lq_full    = (count == CNT_W'(LQ_DEPTH));
    assign lq_empty   = (count == '0);
    assign push       = lsu_req_i && !lq_full;
    assign pop        = lsu_rvalid_i && !lq_empty;
    assign load_win   = pop;
    assign head       = lq_mem[rd_ptr];

    assign ex_ready_o      = !load_win;
    assign lsu_req_ready_o = !lq_full;
    assign lq_empty_o      = lq_empty;

    // Extract the addressed lane of the returned word and extend it.
    // Half loads only look at offset[1], so misaligned offsets snap down.
    always_comb begin
        half_lane = head.offset[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
        byte_lane = lsu_rdata_i[{head.offset, 3'b000} +: 8];
        case (head.ltype)
            2'b01:   load_data = {{(DATA_WIDTH-16){head.sign_ext & half_lane[15]}}, half_lane};
            2'b10:   load_data = {{(DATA_WIDTH-8){head.sign_ext & byte_lane[7]}}, byte_lane};
            default: load_data = lsu_rdata_i;
        endcase
    end

    // An entry is live when its distance from the read pointer is below
    // the occupancy count; only live entries can raise a hazard.
    for (genvar g = 0; g < LQ_DEPTH; g++) begin : g_entry
        assign rel_pos[g]     = PTR_W'(g) - rd_ptr;
        assign entry_vld[g]   = ({1'b0, rel_pos[g]} < count);
        assign entry_hit_a[g] = entry_vld[g] && (lq_mem[g].waddr == raddr_a_i);
        assign entry_hit_b[g] = entry_vld[g] && (lq_mem[g].waddr == raddr_b_i);
    end

    // Operand hazard: pending load destination or write still in the
    // output register; x0 is hardwired and never stalls.
    always_comb begin
        hit_a = (raddr_a_i != '0) &&
                ((|entry_hit_a) || (rf_we_o && (rf_waddr_o == raddr_a_i)));
        hit_b = (raddr_b_i != '0) &&
                ((|entry_hit_b) || (rf_we_o && (rf_waddr_o == raddr_b_i)));
        hazard_o = hit_a || hit_b;
    end

    // Descriptor storage; contents are don't-care until counted live.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_mem[wr_ptr] <= '{waddr:    lsu_req_waddr_i,
                                ltype:    lsu_req_type_i,
                                sign_ext: lsu_req_sign_ext_i,
                                offset:   lsu_req_offset_i};
        end
    end

    // Queue pointers, sticky error and the registered write-port arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            lsu_err_o  <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (lsu_rvalid_i && lq_empty) lsu_err_o <= 1'b1;

            if (load_win) begin
                rf_we_o    <= (head.waddr != '0);
                rf_waddr_o <= head.waddr;
                rf_wdata_o <= load_data;
            end else if (ex_we_i) begin
                rf_we_o    <= (ex_waddr_i != '0);
                rf_waddr_o <= ex_waddr_i;
                rf_wdata_o <= ex_wdata_i;
            end else begin
                rf_we_o    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_wb_stage.sv
// Randomised bench for the write-back stage against a queue-based model.
module tb_zeroriscy_wb_stage;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk, rst;
    logic          ex_we_i, ex_ready_o;
    logic [AW-1:0] ex_waddr_i;
    logic [DW-1:0] ex_wdata_i;
    logic          lsu_req_i, lsu_req_sign_ext_i, lsu_req_ready_o;
    logic [AW-1:0] lsu_req_waddr_i;
    logic [1:0]    lsu_req_type_i, lsu_req_offset_i;
    logic          lsu_rvalid_i;
    logic [DW-1:0] lsu_rdata_i;
    logic [AW-1:0] raddr_a_i, raddr_b_i;
    logic          hazard_o, lq_empty_o, lsu_err_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          rf_we_o;

    zeroriscy_wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o),
        .lsu_req_i(lsu_req_i), .lsu_req_waddr_i(lsu_req_waddr_i),
        .lsu_req_type_i(lsu_req_type_i), .lsu_req_sign_ext_i(lsu_req_sign_ext_i),
        .lsu_req_offset_i(lsu_req_offset_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .hazard_o(hazard_o), .lq_empty_o(lq_empty_o), .lsu_err_o(lsu_err_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] a;
        logic [1:0] t;
        logic       s;
        logic [1:0] o;
    } desc_t;

    typedef struct {
        logic        rst;
        logic        exwe;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        req;
        logic [4:0]  qa;
        logic [1:0]  qt;
        logic        qs;
        logic [1:0]  qo;
        logic        rv;
        logic [31:0] rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
    } stim_t;

    int n_chk = 0;
    int n_fail = 0;

    desc_t       lq[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load extraction expressed as shift-and-mask arithmetic.
    function automatic logic [31:0] ext(input logic [1:0] t, input logic s,
                                        input logic [1:0] o, input logic [31:0] d);
        logic [31:0] v;
        if (t == 2'd1) begin
            v = (d >> (o[1] ? 16 : 0)) & 32'h0000FFFF;
            if (s && v[15]) v = v | 32'hFFFF0000;
        end else if (t == 2'd2) begin
            v = (d >> (32'(o) * 8)) & 32'h000000FF;
            if (s && v[7]) v = v | 32'hFFFFFF00;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic m_hazard(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        if (m_we && m_waddr == ra) return 1'b1;
        foreach (lq[i]) if (lq[i].a == ra) return 1'b1;
        return 1'b0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, exwe: 1'b0, exa: 5'd0, exd: 32'd0, req: 1'b0, qa: 5'd0,
              qt: 2'd0, qs: 1'b0, qo: 2'd0, rv: 1'b0, rd: 32'd0, ra: 5'd0, rb: 5'd0};
        return s;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registers.
    task automatic cycle(input stim_t s, output logic rdy);
        desc_t h;
        logic  win, full;
        @(negedge clk);
        rst = s.rst; ex_we_i = s.exwe; ex_waddr_i = s.exa; ex_wdata_i = s.exd;
        lsu_req_i = s.req; lsu_req_waddr_i = s.qa; lsu_req_type_i = s.qt;
        lsu_req_sign_ext_i = s.qs; lsu_req_offset_i = s.qo;
        lsu_rvalid_i = s.rv; lsu_rdata_i = s.rd;
        raddr_a_i = s.ra; raddr_b_i = s.rb;
        #1;
        win  = s.rv && (lq.size() != 0);
        full = (lq.size() == DEPTH);
        rdy  = ex_ready_o;
        chk("ex_ready", ex_ready_o, !win);
        chk("req_ready", lsu_req_ready_o, !full);
        chk("lq_empty", lq_empty_o, lq.size() == 0);
        chk("hazard", hazard_o, m_hazard(s.ra) || m_hazard(s.rb));
        chk("lsu_err", lsu_err_o, m_err);
        if (s.rst) begin
            lq.delete();
            m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_err = 1'b0;
        end else begin
            if (win) begin
                h = lq.pop_front();
                m_we = (h.a != 5'd0); m_waddr = h.a; m_wdata = ext(h.t, h.s, h.o, s.rd);
            end else if (s.exwe) begin
                m_we = (s.exa != 5'd0); m_waddr = s.exa; m_wdata = s.exd;
            end else begin
                m_we = 1'b0;
            end
            if (s.rv && lq.size() == 0 && !win) m_err = 1'b1;
            if (s.req && !full) lq.push_back('{a: s.qa, t: s.qt, s: s.qs, o: s.qo});
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we_o, m_we);
        chk("rf_waddr", rf_waddr_o, m_waddr);
        chk("rf_wdata", rf_wdata_o, m_wdata);
    endtask

    initial begin
        stim_t      s;
        logic       rdy;
        logic       ex_pend;
        logic [4:0] ex_a;
        logic [31:0] ex_d;

        // Bring the design out of power-up before any checking starts.
        rst = 1'b1; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; lsu_req_i = 0;
        lsu_req_waddr_i = 0; lsu_req_type_i = 0; lsu_req_sign_ext_i = 0;
        lsu_req_offset_i = 0; lsu_rvalid_i = 0; lsu_rdata_i = 0;
        raddr_a_i = 0; raddr_b_i = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
        repeat (2) @(posedge clk);

        // Reset then idle
        s = idle(); s.rst = 1'b1; cycle(s, rdy);
        s = idle(); cycle(s, rdy);

        // EX writes
        s = idle(); s.exwe = 1; s.exa = 5'd5; s.exd = 32'hDEADBEEF; cycle(s, rdy);
        chk("ex_x5_addr", rf_waddr_o, 32'd5);
        chk("ex_x5_data", rf_wdata_o, 32'hDEADBEEF);
        s = idle(); s.exwe = 1; s.exa = 5'd0; s.exd = 32'h1234; cycle(s, rdy);
        chk("ex_x0_we", rf_we_o, 32'd0);

        // Signed byte, offset 2
        s = idle(); s.req = 1; s.qa = 5'd7; s.qt = 2'd2; s.qs = 1; s.qo = 2'd2; cycle(s, rdy);
        s = idle(); s.rv = 1; s.rd = 32'h12C45678; cycle(s, rdy);
        chk("ld_byte_data", rf_wdata_o, 32'hFFFFFFC4);
        chk("ld_byte_addr", rf_waddr_o, 32'd7);
        // Zero-extended half, offset 2
        s = idle(); s.req = 1; s.qa = 5'd8; s.qt = 2'd1; s.qs = 0; s.qo = 2'd2; cycle(s, rdy);
        s = idle(); s.rv = 1; s.rd = 32'h12C45678; cycle(s, rdy);
        chk("ld_half_data", rf_wdata_o, 32'h000012C4);

        // Collision: load wins, EX held then written
        s = idle(); s.req = 1; s.qa = 5'd4; cycle(s, rdy);
        s = idle(); s.exwe = 1; s.exa = 5'd3; s.exd = 32'h33; s.rv = 1; s.rd = 32'h44444444;
        cycle(s, rdy);
        chk("collide_rdy", rdy, 32'd0);
        chk("collide_first", rf_waddr_o, 32'd4);
        s = idle(); s.exwe = 1; s.exa = 5'd3; s.exd = 32'h33; cycle(s, rdy);
        chk("collide_second", rf_waddr_o, 32'd3);

        // Fill, drop while full, push+pop at count 1, wrap
        s = idle(); s.req = 1; s.qa = 5'd10; cycle(s, rdy);
        s = idle(); s.req = 1; s.qa = 5'd11; cycle(s, rdy);
        s = idle(); s.req = 1; s.qa = 5'd12; cycle(s, rdy);
        s = idle(); s.rv = 1; s.rd = 32'hA; cycle(s, rdy);
        s = idle(); s.rv = 1; s.rd = 32'hB; s.req = 1; s.qa = 5'd13; cycle(s, rdy);
        chk("pushpop_addr", rf_waddr_o, 32'd11);
        s = idle(); s.ra = 5'd13; cycle(s, rdy);
        s = idle(); s.rv = 1; s.rd = 32'hD; cycle(s, rdy);
        chk("wrap_addr", rf_waddr_o, 32'd13);

        // Hazard on pending load to x9 through write-back
        s = idle(); s.req = 1; s.qa = 5'd9; cycle(s, rdy);
        s = idle(); s.ra = 5'd9; cycle(s, rdy);
        s = idle(); s.ra = 5'd9; s.rv = 1; s.rd = 32'h99; cycle(s, rdy);
        s = idle(); s.ra = 5'd9; cycle(s, rdy);
        s = idle(); s.ra = 5'd9; cycle(s, rdy);
        s = idle(); s.ra = 5'd0; s.rb = 5'd0; cycle(s, rdy);

        // Error on rvalid with empty queue, sticky until reset
        s = idle(); s.rv = 1; s.rd = 32'hEE; cycle(s, rdy);
        chk("err_set", lsu_err_o, 32'd1);
        s = idle(); cycle(s, rdy);
        s = idle(); cycle(s, rdy);
        s = idle(); s.rst = 1; cycle(s, rdy);
        chk("err_clr", lsu_err_o, 32'd0);

        // Randomised traffic with occasional mid-flight reset
        ex_pend = 0; ex_a = 0; ex_d = 0;
        for (int c = 0; c < 1500; c++) begin
            s = idle();
            s.rst = ($urandom_range(0, 79) == 0);
            if (s.rst) begin
                ex_pend = 0;
            end else begin
                if (!ex_pend && $urandom_range(0, 1) == 1) begin
                    ex_pend = 1; ex_a = 5'($urandom_range(0, 15)); ex_d = $urandom;
                end
                s.exwe = ex_pend; s.exa = ex_a; s.exd = ex_d;
                s.req = ($urandom_range(0, 2) == 0);
                s.qa  = 5'($urandom_range(0, 15));
                s.qt  = 2'($urandom_range(0, 3));
                s.qs  = 1'($urandom_range(0, 1));
                s.qo  = 2'($urandom_range(0, 3));
                s.rv  = (lq.size() != 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 39) == 0);
                s.rd  = $urandom;
            end
            s.ra = 5'($urandom_range(0, 15));
            s.rb = 5'($urandom_range(0, 15));
            cycle(s, rdy);
            if (s.exwe && rdy) ex_pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
